// File: rtl/video_pkg.sv
// video_pkg: shared VRAM/pixel widths and the line-fetch state encoding.
//   VRAM_AW/VRAM_DW  VRAM video port address/data width
//   PIX_W            pixel index width
//   VRAM_RD_LATENCY  clocks from read issue to valid read data
package video_pkg;
  localparam int VRAM_AW = 16;
  localparam int VRAM_DW = 16;
  localparam int PIX_W = 8;
  localparam int VRAM_RD_LATENCY = 1;
  typedef enum logic [1:0] {FS_IDLE, FS_FETCH, FS_DONE} fetch_state_t;
endpackage

// File: rtl/vram_line_fetcher_if.sv
// vram_line_fetcher_if: VRAM video-port bus between the line fetcher and the VRAM.
//   addr  word address (master -> slave)
//   re    read strobe, one word per cycle (master -> slave)
//   we    write strobe, always 0 from the fetcher (master -> slave)
//   data  read data, valid one clock after re (slave -> master)
interface vram_line_fetcher_if;
  import video_pkg::*;
  logic [VRAM_AW-1:0] addr;
  logic re;
  logic we;
  logic [VRAM_DW-1:0] data;
  modport master (output addr, re, we, input data);
  modport slave (input addr, re, we, output data);
endinterface

// File: rtl/video_word_fifo.sv
// video_word_fifo: synchronous show-ahead word FIFO with flush and occupancy count.
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          empties the FIFO, overriding push/pop
//   push, wdata    write one word (push with pop honoured even when full)
//   pop, rdata     rdata is the head word; pop on empty is ignored
//   count          words held (0..DEPTH)
//   empty, full    occupancy flags
module video_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  // The writer's flow control must keep a word from ever being dropped.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && full && !do_pop));
endmodule

// File: rtl/vram_line_fetcher.sv
// vram_line_fetcher: streams one scanline of VRAM words into a FIFO and unpacks 8bpp pixels.
//   clk, rst_n     clock, asynchronous active-low reset
//   line_start_i   pulse: start (or abort and restart) a scanline fetch
//   line_base_i    first word address, sampled with line_start_i
//   line_words_i   words to fetch, sampled with line_start_i (0 = none)
//   vid            VRAM video port (master side), read-only
//   pix_req_i      consume one pixel this cycle
//   pix_o          registered pixel index, low byte of each word first
//   pix_valid_o    pix_o was loaded from FIFO data this cycle
//   busy_o         current line fetch not yet complete
//   underflow_o    sticky: pixel requested with none available; cleared by line start
module vram_line_fetcher
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start_i,
  input  logic [VRAM_AW-1:0]  line_base_i,
  input  logic [LEN_W-1:0]    line_words_i,
  vram_line_fetcher_if.master vid,
  input  logic                pix_req_i,
  output logic [PIX_W-1:0]    pix_o,
  output logic                pix_valid_o,
  output logic                busy_o,
  output logic                underflow_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state;
  logic [VRAM_AW-1:0] ptr, addr;
  logic [LEN_W-1:0] words_left;
  logic re, pend, byte_sel;
  logic [1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [VRAM_DW-1:0] head;
  logic fifo_empty, fifo_full, push, pop, take, room;
  // pend marks a read whose data is on vid.data now; a line start drops it as stale.
  assign inflight = {1'b0, re} + {1'b0, pend};
  // Reserve FIFO space for every outstanding read so a returning word always fits.
  assign room = ({1'b0, fifo_count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign push = pend && !line_start_i;
  assign take = pix_req_i && !line_start_i && !fifo_empty;
  assign pop = take && byte_sel;
  assign vid.addr = addr;
  assign vid.re = re;
  assign vid.we = 1'b0;
  assign busy_o = state != FS_IDLE;
  video_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(VRAM_DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (line_start_i),
    .push  (push),
    .wdata (vid.data),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_IDLE;
      ptr <= '0;
      addr <= '0;
      words_left <= '0;
      re <= 1'b0;
      pend <= 1'b0;
    end else if (line_start_i) begin
      state <= line_words_i != '0 ? FS_FETCH : FS_IDLE;
      ptr <= line_base_i;
      words_left <= line_words_i;
      re <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= re;
      re <= 1'b0;
      case (state)
        FS_FETCH:
          if (words_left != '0 && room) begin
            re <= 1'b1;
            addr <= ptr;
            ptr <= ptr + 1'b1;
            words_left <= words_left - 1'b1;
            state <= words_left == LEN_W'(1) ? FS_DONE : FS_FETCH;
          end
        // The last read is on the bus on entry; once it has gone, its data lands this edge.
        FS_DONE: state <= re ? FS_DONE : FS_IDLE;
        default: state <= FS_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_o <= '0;
      pix_valid_o <= 1'b0;
      underflow_o <= 1'b0;
      byte_sel <= 1'b0;
    end else if (line_start_i) begin
      pix_valid_o <= 1'b0;
      underflow_o <= 1'b0;
      byte_sel <= 1'b0;
    end else if (pix_req_i) begin
      pix_o <= fifo_empty ? '0 : (byte_sel ? head[15:8] : head[7:0]);
      pix_valid_o <= !fifo_empty;
      underflow_o <= underflow_o | fifo_empty;
      byte_sel <= byte_sel ^ take;
    end else begin
      pix_valid_o <= 1'b0;
    end
  end
  a_fifo_never_full_on_push: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));
endmodule
